// File: rtl/demux3_stream.sv
// demux3_stream: registered 1-to-3 stream demultiplexer.
// A single holding register takes one beat at a time and presents it on the
// channel named by its destination select. Beats addressed to 2'b11 have no
// destination: they are accepted, discarded and counted in a saturating counter.
module demux3_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data_a,
  output logic             out_valid_a,
  input  logic             out_ready_a,
  output logic [WIDTH-1:0] out_data_b,
  output logic             out_valid_b,
  input  logic             out_ready_b,
  output logic [WIDTH-1:0] out_data_c,
  output logic             out_valid_c,
  input  logic             out_ready_c,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [1:0]       hold_dest_q, hold_dest_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic hold_valid;
  logic dest_ready;
  logic drain;
  logic accept;
  logic load;
  logic drop;

  // State, holding register and drop counter; reset discards any held beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      hold_data_q <= '0;
      hold_dest_q <= 2'b00;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_dest_q <= hold_dest_d;
      drop_q      <= drop_d;
    end
  end

  // Handshake decode and next-state logic. in_ready depends only on the held
  // state and the selected consumer's ready, never on in_valid.
  always_comb begin
    hold_valid  = (state_q == FULL);

    // Only the consumer the held beat is addressed to can drain it.
    case (hold_dest_q)
      2'b00:   dest_ready = out_ready_a;
      2'b01:   dest_ready = out_ready_b;
      2'b10:   dest_ready = out_ready_c;
      default: dest_ready = 1'b0;
    endcase

    drain       = hold_valid && dest_ready;
    in_ready    = !hold_valid || drain;
    accept      = in_valid && in_ready;
    load        = accept && (in_sel != 2'b11);
    drop        = accept && (in_sel == 2'b11);

    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_dest_d = hold_dest_q;
    drop_d      = drop_q;

    if (load) begin
      // Covers both filling from EMPTY and reload-on-drain while FULL.
      state_d     = FULL;
      hold_data_d = in_data;
      hold_dest_d = in_sel;
    end else if (drain) begin
      state_d = EMPTY;
    end

    // Saturate rather than wrap so a flood of bad selects stays visible.
    if (drop && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Output decode: one-hot valids, shared payload.
  always_comb begin
    out_valid_a = hold_valid && (hold_dest_q == 2'b00);
    out_valid_b = hold_valid && (hold_dest_q == 2'b01);
    out_valid_c = hold_valid && (hold_dest_q == 2'b10);
    out_data_a  = hold_data_q;
    out_data_b  = hold_data_q;
    out_data_c  = hold_data_q;
    drop_count  = drop_q;
  end

endmodule
